// File: rtl/sample_fetch_buffer.sv
// sample_fetch_buffer
// Streams a region of 16-bit sample memory into a small FIFO for the audio
// output stage. One memory read is outstanding at a time. A fetch can loop
// over the region forever or run once, and can be aborted with stop. The
// output stage pops at audio rate and is told explicitly when it underruns.

module sample_fetch_buffer #(
  parameter int DEPTH    = 16,
  parameter int READ_LAT = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        start,
  input  logic [15:0] base_addr,
  input  logic [15:0] length,
  input  logic        loop,
  input  logic        stop,
  output logic        mem_rd,
  output logic [15:0] mem_addr,
  input  logic [15:0] mem_rdata,
  input  logic        sample_req,
  output logic [15:0] sample_out,
  output logic        sample_valid,
  output logic        underrun,
  output logic        busy,
  output logic        done
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int WCW = $clog2(READ_LAT + 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    STORE
  } state_t;

  state_t          state_q, state_d;
  logic [15:0]     base_q, base_d;
  logic [15:0]     len_q, len_d;
  logic            loop_q, loop_d;
  logic [15:0]     ptr_q, ptr_d;
  logic [15:0]     remaining_q, remaining_d;
  logic            stop_q, stop_d;
  logic [WCW-1:0]  wait_cnt_q, wait_cnt_d;
  logic            mem_rd_q, mem_rd_d;
  logic [15:0]     mem_addr_q, mem_addr_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [15:0]     fifo_mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [15:0]     sample_out_q, sample_out_d;
  logic            sample_valid_q, sample_valid_d;
  logic            underrun_q, underrun_d;

  logic            push;
  logic            pop;
  logic            stop_now;

  assign stop_now = stop_q | stop;

  // Fetch sequencer: picks the next state and the read strobe, and tracks
  // the address pointer and words remaining in the current pass.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    len_d       = len_q;
    loop_d      = loop_q;
    ptr_d       = ptr_q;
    remaining_d = remaining_q;
    stop_d      = stop_q;
    wait_cnt_d  = wait_cnt_q;
    mem_rd_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    push        = 1'b0;

    if (state_q != IDLE && stop) begin
      stop_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        stop_d = 1'b0;
        if (start && !done_q) begin
          if (length != 16'd0) begin
            base_d      = base_addr;
            len_d       = length;
            loop_d      = loop;
            ptr_d       = base_addr;
            remaining_d = length;
            busy_d      = 1'b1;
            state_d     = ISSUE;
          end else begin
            done_d = 1'b1;
          end
        end
      end

      ISSUE: begin
        if (stop_now) begin
          stop_d  = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (count_q < CW'(DEPTH)) begin
          mem_rd_d   = 1'b1;
          mem_addr_d = ptr_q;
          wait_cnt_d = '0;
          state_d    = WAIT;
        end
      end

      WAIT: begin
        if (wait_cnt_q == WCW'(READ_LAT - 1)) begin
          state_d = STORE;
        end else begin
          wait_cnt_d = wait_cnt_q + WCW'(1);
        end
      end

      STORE: begin
        push        = 1'b1;
        ptr_d       = ptr_q + 16'd1;
        remaining_d = remaining_q - 16'd1;
        if (stop_now) begin
          stop_d  = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (remaining_q == 16'd1) begin
          if (loop_q) begin
            ptr_d       = base_q;
            remaining_d = len_q;
            state_d     = ISSUE;
          end else begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end else begin
          state_d = ISSUE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FIFO bookkeeping: pops on request when non-empty, flags an underrun
  // otherwise, and keeps the last popped sample on the output.
  always_comb begin
    pop            = sample_req && (count_q != '0);
    sample_valid_d = pop;
    underrun_d     = sample_req && (count_q == '0);
    sample_out_d   = sample_out_q;
    rd_ptr_d       = rd_ptr_q;
    wr_ptr_d       = wr_ptr_q;
    if (pop) begin
      sample_out_d = fifo_mem_q[rd_ptr_q];
      rd_ptr_d     = rd_ptr_q + AW'(1);
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    count_d = count_q + CW'(push) - CW'(pop);
  end

  // State and control registers; reset discards any read still in flight.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q        <= IDLE;
      base_q         <= '0;
      len_q          <= '0;
      loop_q         <= 1'b0;
      ptr_q          <= '0;
      remaining_q    <= '0;
      stop_q         <= 1'b0;
      wait_cnt_q     <= '0;
      mem_rd_q       <= 1'b0;
      mem_addr_q     <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      sample_out_q   <= '0;
      sample_valid_q <= 1'b0;
      underrun_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      base_q         <= base_d;
      len_q          <= len_d;
      loop_q         <= loop_d;
      ptr_q          <= ptr_d;
      remaining_q    <= remaining_d;
      stop_q         <= stop_d;
      wait_cnt_q     <= wait_cnt_d;
      mem_rd_q       <= mem_rd_d;
      mem_addr_q     <= mem_addr_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      sample_out_q   <= sample_out_d;
      sample_valid_q <= sample_valid_d;
      underrun_q     <= underrun_d;
    end
  end

  // FIFO storage: captures returning read data during STORE.
  always_ff @(posedge Clk) begin
    if (push && !Reset) begin
      fifo_mem_q[wr_ptr_q] <= mem_rdata;
    end
  end

  assign mem_rd       = mem_rd_q;
  assign mem_addr     = mem_addr_q;
  assign sample_out   = sample_out_q;
  assign sample_valid = sample_valid_q;
  assign underrun     = underrun_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_sample_fetch_buffer.sv
// tb_sample_fetch_buffer
// Directed bench for sample_fetch_buffer. Stimulus pushes expected read
// addresses, samples and underruns into queues; a monitor on the falling
// edge pops and compares whenever the DUT presents an event.

module tb_sample_fetch_buffer;

  localparam int DEPTH = 16;
  localparam int RL    = 2;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] base_addr = '0;
  logic [15:0] length = '0;
  logic        loop = 1'b0;
  logic        stop = 1'b0;
  logic        sample_req = 1'b0;
  logic [15:0] mem_rdata;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic [15:0] sample_out;
  logic        sample_valid;
  logic        underrun;
  logic        busy;
  logic        done;

  int          n_checks = 0;
  int          n_pass = 0;
  int          reads_seen = 0;
  int          done_seen = 0;
  int          pending_underruns = 0;
  logic [15:0] exp_addr_q [$];
  logic [15:0] exp_sample_q [$];
  logic [15:0] exp_last_sample = '0;

  logic [RL-1:0] pipe_v = '0;
  logic [15:0]   pipe_a [RL];

  sample_fetch_buffer #(.DEPTH(DEPTH), .READ_LAT(RL)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .start        (start),
    .base_addr    (base_addr),
    .length       (length),
    .loop         (loop),
    .stop         (stop),
    .mem_rd       (mem_rd),
    .mem_addr     (mem_addr),
    .mem_rdata    (mem_rdata),
    .sample_req   (sample_req),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .underrun     (underrun),
    .busy         (busy),
    .done         (done)
  );

  // Free-running clock
  always #5 Clk = ~Clk;

  // Sample memory content: a fixed scramble of the address
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return a ^ 16'h5A3C;
  endfunction

  // Memory model: data is valid exactly RL cycles after the read strobe
  always @(posedge Clk) begin
    pipe_v[0] <= mem_rd;
    pipe_a[0] <= mem_addr;
    for (int i = 1; i < RL; i++) begin
      pipe_v[i] <= pipe_v[i-1];
      pipe_a[i] <= pipe_a[i-1];
    end
  end

  assign mem_rdata = pipe_v[RL-1] ? mem_word(pipe_a[RL-1]) : 16'hDEAD;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic flag_failure(input string name);
    n_checks++;
    $display("[TB] FAIL %s: got unexpected DUT event, expected none", name);
  endtask

  task automatic applyStimulus(input logic [15:0] base, input logic [15:0] len, input logic lp);
    @(posedge Clk); #1;
    start = 1'b1; base_addr = base; length = len; loop = lp;
    @(posedge Clk); #1;
    start = 1'b0;
  endtask

  task automatic pulse_req();
    @(posedge Clk); #1;
    sample_req = 1'b1;
    @(posedge Clk); #1;
    sample_req = 1'b0;
  endtask

  task automatic pop_sample(input logic [15:0] expv);
    exp_sample_q.push_back(expv);
    pulse_req();
  endtask

  task automatic pop_underrun();
    pending_underruns++;
    pulse_req();
  endtask

  task automatic wait_done(input int max_cycles, output logic seen, output logic busy_held);
    seen = 1'b0;
    busy_held = 1'b1;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge Clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (busy !== 1'b1) busy_held = 1'b0;
    end
  endtask

  // Monitor: every DUT event must match the next queued expectation
  always @(negedge Clk) begin
    if (!Reset) begin
      if (mem_rd === 1'b1) begin
        reads_seen++;
        if (exp_addr_q.size() == 0) flag_failure("unexpected_read");
        else checkOutput("mem_addr", 32'(mem_addr), 32'(exp_addr_q.pop_front()));
      end
      if (sample_valid === 1'b1) begin
        if (exp_sample_q.size() == 0) flag_failure("unexpected_sample");
        else begin
          exp_last_sample = exp_sample_q.pop_front();
          checkOutput("sample_out", 32'(sample_out), 32'(exp_last_sample));
        end
      end
      if (underrun === 1'b1) begin
        if (pending_underruns == 0) flag_failure("unexpected_underrun");
        else begin
          pending_underruns--;
          checkOutput("underrun_sample_hold", 32'(sample_out), 32'(exp_last_sample));
        end
      end
      if (sample_valid === 1'b1 && underrun === 1'b1) flag_failure("valid_with_underrun");
      if (done === 1'b1) done_seen++;
    end
  end

  // Watchdog so the bench never hangs
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios
  initial begin
    logic seen;
    logic held;
    int   r0;
    int   r_end;
    int   d0;
    int   k;

    repeat (3) @(posedge Clk);
    #1 Reset = 1'b0;
    @(negedge Clk);
    checkOutput("rst_mem_rd", 32'(mem_rd), 32'd0);
    checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_sample_valid", 32'(sample_valid), 32'd0);
    checkOutput("rst_underrun", 32'(underrun), 32'd0);
    checkOutput("rst_sample_out", 32'(sample_out), 32'd0);

    // T4: pop on empty FIFO straight after reset
    pop_underrun();
    repeat (3) @(posedge Clk);

    // T1: four words from 0x0010, plus an ignored start while busy
    exp_addr_q.push_back(16'h0010);
    exp_addr_q.push_back(16'h0011);
    exp_addr_q.push_back(16'h0012);
    exp_addr_q.push_back(16'h0013);
    applyStimulus(16'h0010, 16'd4, 1'b0);
    @(negedge Clk);
    checkOutput("t1_busy_after_start", 32'(busy), 32'd1);
    applyStimulus(16'h0999, 16'd5, 1'b0);
    wait_done(60, seen, held);
    checkOutput("t1_done", 32'(seen), 32'd1);
    checkOutput("t1_busy_held", 32'(held), 32'd1);
    checkOutput("t1_busy_at_done", 32'(busy), 32'd0);
    pop_sample(16'h5A2C);
    pop_sample(16'h5A2D);
    pop_sample(16'h5A2E);
    pop_sample(16'h5A2F);
    pop_underrun();

    // Zero length: done next cycle, never busy, no reads
    applyStimulus(16'h0500, 16'd0, 1'b0);
    @(negedge Clk);
    checkOutput("len0_done", 32'(done), 32'd1);
    checkOutput("len0_busy", 32'(busy), 32'd0);
    repeat (5) @(posedge Clk);

    // T2: DEPTH+4 words with no pops; fetch must stall at a full FIFO
    r0 = reads_seen;
    for (int i = 0; i < DEPTH + 4; i++) exp_addr_q.push_back(16'h0100 + 16'(i));
    applyStimulus(16'h0100, 16'(DEPTH + 4), 1'b0);
    repeat (100) @(posedge Clk);
    @(negedge Clk);
    checkOutput("t2_reads_at_stall", 32'(reads_seen - r0), 32'(DEPTH));
    checkOutput("t2_busy_while_stalled", 32'(busy), 32'd1);
    for (int i = 0; i < 4; i++) pop_sample(mem_word(16'h0100 + 16'(i)));
    wait_done(60, seen, held);
    checkOutput("t2_done", 32'(seen), 32'd1);
    checkOutput("t2_total_reads", 32'(reads_seen - r0), 32'(DEPTH + 4));
    for (int i = 4; i < DEPTH + 4; i++) pop_sample(mem_word(16'h0100 + 16'(i)));
    pop_underrun();

    // T3: address wrap FFFF -> 0000
    exp_addr_q.push_back(16'hFFFE);
    exp_addr_q.push_back(16'hFFFF);
    exp_addr_q.push_back(16'h0000);
    exp_addr_q.push_back(16'h0001);
    applyStimulus(16'hFFFE, 16'd4, 1'b0);
    wait_done(60, seen, held);
    checkOutput("t3_done", 32'(seen), 32'd1);
    pop_sample(16'hA5C2);
    pop_sample(16'hA5C3);
    pop_sample(16'h5A3C);
    pop_sample(16'h5A3D);

    // T5: loop over 3 words with steady pops, then stop
    r0 = reads_seen;
    d0 = done_seen;
    for (int i = 0; i < 90; i++) exp_addr_q.push_back(16'h0200 + 16'(i % 3));
    applyStimulus(16'h0200, 16'd3, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge Clk);
      if (reads_seen - r0 >= 12) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("t5_prefill", 32'(seen), 32'd1);
    k = 0;
    for (int i = 0; i < 10; i++) begin
      pop_sample(mem_word(16'h0200 + 16'(k % 3)));
      k++;
      repeat (2) @(posedge Clk);
    end
    @(negedge Clk);
    checkOutput("t5_busy_looping", 32'(busy), 32'd1);
    checkOutput("t5_no_done_looping", 32'(done_seen - d0), 32'd0);
    @(posedge Clk); #1 stop = 1'b1;
    @(posedge Clk); #1 stop = 1'b0;
    wait_done(20, seen, held);
    checkOutput("t5_stop_done", 32'(seen), 32'd1);
    r_end = reads_seen;
    repeat (20) @(negedge Clk);
    checkOutput("t5_no_reads_after_stop", 32'(reads_seen - r_end), 32'd0);
    exp_addr_q.delete();
    for (int i = 0; i < (r_end - r0) - 10; i++) begin
      pop_sample(mem_word(16'h0200 + 16'(k % 3)));
      k++;
    end
    pop_underrun();

    // T6: reset while a read is in flight
    exp_addr_q.push_back(16'h0300);
    applyStimulus(16'h0300, 16'd5, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      if (mem_rd === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("t6_read_issued", 32'(seen), 32'd1);
    @(posedge Clk); #1 Reset = 1'b1;
    @(posedge Clk); #1 Reset = 1'b0;
    exp_last_sample = 16'h0000;
    @(negedge Clk);
    checkOutput("t6_busy", 32'(busy), 32'd0);
    checkOutput("t6_mem_rd", 32'(mem_rd), 32'd0);
    checkOutput("t6_sample_out", 32'(sample_out), 32'd0);
    repeat (5) @(posedge Clk);
    pop_underrun();
    repeat (5) @(posedge Clk);
    @(negedge Clk);

    checkOutput("done_pulses", 32'(done_seen), 32'd5);
    checkOutput("addr_queue_drained", 32'(exp_addr_q.size()), 32'd0);
    checkOutput("sample_queue_drained", 32'(exp_sample_q.size()), 32'd0);
    checkOutput("underruns_drained", 32'(pending_underruns), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
